// File: rtl/seq_row_multiplier.sv
// Multi-cycle WIDTH x WIDTH multiplier, signed or unsigned, reusing one bank of BITS_PER_CYCLE partial-product rows.
// Latency: K = WIDTH/BITS_PER_CYCLE edges from acceptance to out_valid; in_ready only while idle, result held until out_ready.
module seq_row_multiplier #(
    parameter int WIDTH          = 4,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     q,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);
    localparam int K  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [2*WIDTH-1:0]   m_sh_q, m_sh_d;
    logic [WIDTH-1:0]     q_sr_q, q_sr_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic                 m_neg, q_neg;
    logic [WIDTH-1:0]     m_abs, q_abs;
    logic [2*WIDTH-1:0]   pp_sum, acc_sum;

    always_comb begin
        m_neg = is_signed & m[WIDTH-1];
        q_neg = is_signed & q[WIDTH-1];
        // Unsigned WIDTH-bit magnitude keeps -2^(WIDTH-1) exact
        m_abs = m_neg ? (~m + 1'b1) : m;
        q_abs = q_neg ? (~q + 1'b1) : q;

        // The multiplicand is kept pre-shifted to the current offset
        pp_sum = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (q_sr_q[j]) begin
                pp_sum = pp_sum + (m_sh_q << j);
            end
        end
        acc_sum = acc_q + pp_sum;

        state_d   = state_q;
        m_sh_d    = m_sh_q;
        q_sr_d    = q_sr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    neg_d   = m_neg ^ q_neg;
                    m_sh_d  = {{WIDTH{1'b0}}, m_abs};
                    q_sr_d  = q_abs;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d  = acc_sum;
                m_sh_d = m_sh_q << BITS_PER_CYCLE;
                q_sr_d = q_sr_q >> BITS_PER_CYCLE;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(K - 1)) begin
                    product_d = neg_q ? (~acc_sum + 1'b1) : acc_sum;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            m_sh_q    <= '0;
            q_sr_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_sh_q    <= m_sh_d;
            q_sr_q    <= q_sr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign product   = product_q;

endmodule

// File: tb/tb_seq_row_multiplier.sv
// Self-checking bench: directed table on the default multiplier, back-pressure and async reset
// sequences, then exhaustive sweeps on WIDTH=4/BPC=1, WIDTH=4/BPC=2 and WIDTH=6/BPC=3.
module tb_seq_row_multiplier;
    logic        clk;
    logic        rst;
    logic [5:0]  m_v, q_v;
    logic        sg_v;
    logic [2:0]  iv, ordy, irdy, ov;
    logic [7:0]  p0, p1;
    logic [11:0] p2;

    int n_cmp = 0;
    int n_bad = 0;
    logic [11:0] sb_q[$];

    // dut0: defaults (4,2); dut1: (4,1); dut2: (6,3)
    seq_row_multiplier #(.WIDTH(4), .BITS_PER_CYCLE(2)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
        .m(m_v[3:0]), .q(q_v[3:0]), .is_signed(sg_v),
        .out_valid(ov[0]), .out_ready(ordy[0]), .product(p0));
    seq_row_multiplier #(.WIDTH(4), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
        .m(m_v[3:0]), .q(q_v[3:0]), .is_signed(sg_v),
        .out_valid(ov[1]), .out_ready(ordy[1]), .product(p1));
    seq_row_multiplier #(.WIDTH(6), .BITS_PER_CYCLE(3)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
        .m(m_v), .q(q_v), .is_signed(sg_v),
        .out_valid(ov[2]), .out_ready(ordy[2]), .product(p2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] m;
        logic [3:0] q;
        logic       s;
        logic [7:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] prod_of(input int i);
        case (i)
            0:       prod_of = {4'b0, p0};
            1:       prod_of = {4'b0, p1};
            default: prod_of = p2;
        endcase
    endfunction

    function automatic logic [11:0] ref_prod(input int w, input logic [5:0] mv,
                                             input logic [5:0] qv, input logic s);
        longint a, b, r;
        a = longint'(mv);
        b = longint'(qv);
        if (s && mv[w-1]) a = a - (longint'(1) << w);
        if (s && qv[w-1]) b = b - (longint'(1) << w);
        r = (a * b) & ((longint'(1) << (2 * w)) - 1);
        ref_prod = r[11:0];
    endfunction

    // Push expectation at acceptance, pop and compare when out_valid appears.
    task automatic txn(input int i, input int k, input logic [5:0] mv, input logic [5:0] qv,
                       input logic s, input logic [11:0] exp);
        int lat;
        logic [11:0] e;
        @(negedge clk);
        m_v = mv; q_v = qv; sg_v = s; iv[i] = 1'b1;
        chk("in_ready_idle", irdy[i], 1'b1);
        @(posedge clk);
        sb_q.push_back(exp);
        #1;
        iv[i] = 1'b0;
        m_v = 6'($urandom); q_v = 6'($urandom); sg_v = 1'($urandom);
        lat = 0;
        while (!ov[i] && lat < 20) begin
            chk("in_ready_busy", irdy[i], 1'b0);
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, k);
        e = sb_q.pop_front();
        chk("product", prod_of(i), e);
        @(negedge clk);
        ordy[i] = 1'b1;
        @(posedge clk); #1;
        ordy[i] = 1'b0;
        chk("out_valid_drop", ov[i], 1'b0);
        chk("in_ready_back", irdy[i], 1'b1);
    endtask

    vec_t tbl[7];

    initial begin
        rst = 1'b1; iv = '0; ordy = '0; m_v = '0; q_v = '0; sg_v = 1'b0;
        tbl[0] = '{4'hF, 4'hF, 1'b0, 8'd225};
        tbl[1] = '{4'h8, 4'h8, 1'b1, 8'h40};
        tbl[2] = '{4'h3, 4'hE, 1'b1, 8'hFA};
        tbl[3] = '{4'h3, 4'hE, 1'b0, 8'd42};
        tbl[4] = '{4'h0, 4'h5, 1'b1, 8'h00};
        tbl[5] = '{4'h7, 4'h9, 1'b1, 8'hCF};
        tbl[6] = '{4'h8, 4'h7, 1'b1, 8'hC8};

        #3;
        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready", irdy[i], 1'b1);
            chk("rst_out_valid", ov[i], 1'b0);
            chk("rst_product", prod_of(i), 12'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 7; t++)
            txn(0, 2, {2'b0, tbl[t].m}, {2'b0, tbl[t].q}, tbl[t].s, {4'b0, tbl[t].exp});

        // Back-pressure: result must hold while the consumer stalls
        @(negedge clk);
        m_v = 6'd5; q_v = 6'd3; sg_v = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("bp_valid_rise", ov[0], 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_valid_hold", ov[0], 1'b1);
            chk("bp_product_hold", p0, 8'd15);
            chk("bp_in_ready_low", irdy[0], 1'b0);
        end
        @(negedge clk);
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        chk("bp_release_valid", ov[0], 1'b0);
        chk("bp_release_ready", irdy[0], 1'b1);
        chk("bp_product_kept", p0, 8'd15);

        // Reset in RUN aborts at once, with no clock edge needed
        @(negedge clk);
        m_v = 6'd7; q_v = 6'd5; sg_v = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", ov[0], 1'b0);
        chk("arst_in_ready", irdy[0], 1'b1);
        chk("arst_product", p0, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("arst_no_result", ov[0], 1'b0);
        txn(0, 2, 6'd2, 6'd3, 1'b0, 12'd6);

        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    txn(0, 2, 6'(a), 6'(b), 1'(s), ref_prod(4, 6'(a), 6'(b), 1'(s)));
                    txn(1, 4, 6'(a), 6'(b), 1'(s), ref_prod(4, 6'(a), 6'(b), 1'(s)));
                end
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 64; a++)
                for (int b = 0; b < 64; b++)
                    txn(2, 2, 6'(a), 6'(b), 1'(s), ref_prod(6, 6'(a), 6'(b), 1'(s)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_row_multiplier.md
Name: seq_row_multiplier

Overview:
- Sequential, parametrised successor to the combinational array-multiplier row cells.
- Multiplies two WIDTH-bit operands by reusing one bank of BITS_PER_CYCLE partial-product rows (AND-gate rows plus ripple adders) across several clock cycles.
- Supports unsigned and two's-complement modes.
- Uses valid/ready handshakes on both sides, so it sits between an operand source and a result consumer in the datapath.

Parameters:
- WIDTH, 4, operand width in bits; must be at least 2.
- BITS_PER_CYCLE, 2, multiplier (q) bits consumed per cycle; must divide WIDTH evenly.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands m, q and is_signed are valid
- in_ready  output  1  block can accept operands
- m  input  WIDTH  multiplicand
- q  input  WIDTH  multiplier
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled at acceptance
- out_valid  output  1  product is valid
- out_ready  input  1  consumer accepts the product
- product  output  2*WIDTH  result, exact with no truncation

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, in_ready=1, out_valid=0, product=0, internal accumulator, multiplier shift register and cycle counter all cleared. Reset asserted mid-operation aborts it immediately; the result is discarded and never presented.
- Let K = WIDTH/BITS_PER_CYCLE.
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=1, out_valid=0.
  - Acceptance occurs on a clock edge where in_valid=1.
  - At acceptance, latch sign_m=is_signed&m[WIDTH-1] and sign_q=is_signed&q[WIDTH-1].
  - At acceptance, load |m| and |q| (two's-complement negation when the sign bit is set), clear the accumulator and counter, then go to RUN.
  - Magnitudes are held in WIDTH bits unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1) correctly.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge adds BITS_PER_CYCLE partial products (|m| AND each low bit of the q shift register, weighted by shift) into the 2*WIDTH-bit accumulator at the current offset.
  - Each edge also shifts q right by BITS_PER_CYCLE and increments the counter.
  - On the K-th RUN edge, write the final result to product and go to DONE. The final result is the accumulator negated mod 2^(2*WIDTH) when sign_m XOR sign_q, otherwise the accumulator unchanged.
- DONE:
  - out_valid=1, product held stable, in_ready=0.
  - An edge with out_ready=1 returns to IDLE with out_valid=0; product keeps its last value.
  - With out_ready=0, remain in DONE indefinitely.
- Latency: out_valid rises exactly K clock edges after the acceptance edge (2 edges for the defaults). One result per K+2 cycles at best.
- Operand inputs are ignored outside IDLE. is_signed changes during RUN have no effect.
- Zero operands follow the same timing; there is no early termination.
- A product of zero is never negated to a nonzero value.

Test Plan:
- Defaults, unsigned, m=4'b1111, q=4'b1111, in_valid pulsed one cycle -> out_valid high 2 edges later with product=8'd225; in_ready=0 during RUN/DONE.
- Signed, m=4'b1000 (-8), q=4'b1000 (-8) -> product=8'b01000000 (+64).
- Signed, m=4'b0011 (+3), q=4'b1110 (-2) -> product=8'b11111010 (-6). The same operands with is_signed=0 -> product=8'd42.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> product and out_valid stable, in_ready stays 0. Raise out_ready -> next edge out_valid=0, in_ready=1.
- Assert rst during RUN with m=7, q=5 -> out_valid=0, in_ready=1, product=0 asynchronously with no clock edge. A fresh m=2, q=3 afterwards -> product=6.
- Exhaustive sweep at WIDTH=4, BITS_PER_CYCLE=1 and 2, and again at WIDTH=6, BITS_PER_CYCLE=3: all m, q and both modes against a reference product. Check the latency is exactly K every transaction.
